// File: rtl/demux_pkg.sv
// Shared constants and FSM state encoding for the 1-to-32 bit demux / word assembler.
package demux_pkg;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned SEL_W = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

endpackage

// File: rtl/decoder_5to32.sv
// Index to one-hot write-enable decoder, gated by the transfer strobe. Purely combinational.
module decoder_5to32
  import demux_pkg::*;
#(
  parameter int unsigned P_WIDTH = WIDTH,
  parameter int unsigned P_SEL_W = SEL_W
) (
  input  logic [P_SEL_W-1:0] i_idx,
  input  logic               i_en,
  output logic [P_WIDTH-1:0] o_onehot
);

  always_comb begin
    o_onehot = '0;
    if (i_en) begin
      o_onehot[i_idx] = 1'b1;
    end
  end

endmodule

// File: rtl/demux_1to32_reg.sv
// Registered 1-to-32 bit demultiplexer that reassembles bit-serial data into a word.
// Optional DEMUX_PARITY_EN adds a registered even-parity output valid with word_valid.
module demux_1to32_reg
  import demux_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_bit,
  input  logic [SEL_W-1:0] sel,
  input  logic             auto_inc,
  output logic [WIDTH-1:0] Y,
  output logic [WIDTH-1:0] written,
`ifdef DEMUX_PARITY_EN
  output logic             parity,
`endif
  output logic             word_valid,
  output logic             busy
);

  state_t           r_state;
  logic [WIDTH-1:0] r_y;
  logic [WIDTH-1:0] r_written;
  logic [SEL_W-1:0] r_cnt;
  logic             r_word_valid;
  logic             r_busy;
  logic             r_parity;

  logic             w_xfer;
  logic [SEL_W-1:0] w_idx;
  logic [WIDTH-1:0] w_we;
  logic [WIDTH-1:0] w_y_nxt;
  logic [WIDTH-1:0] w_written_nxt;
  logic             w_done;

  // A restart request wins over a coincident transfer, so the bit is dropped.
  assign w_xfer        = in_valid & r_busy & ~start;
  assign w_idx         = auto_inc ? r_cnt : sel;
  assign w_y_nxt       = in_bit ? (r_y | w_we) : (r_y & ~w_we);
  assign w_written_nxt = r_written | w_we;
  assign w_done        = w_xfer & (&w_written_nxt);

  decoder_5to32 #(
    .P_WIDTH (WIDTH),
    .P_SEL_W (SEL_W)
  ) u_dec (
    .i_idx    (w_idx),
    .i_en     (w_xfer),
    .o_onehot (w_we)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_y          <= '0;
      r_written    <= '0;
      r_cnt        <= '0;
      r_word_valid <= 1'b0;
      r_busy       <= 1'b0;
      r_parity     <= 1'b0;
    end else begin
      r_word_valid <= 1'b0;
      if (start) begin
        // Any state: begin a fresh word.
        r_state   <= ST_FILL;
        r_busy    <= 1'b1;
        r_y       <= '0;
        r_written <= '0;
        r_cnt     <= '0;
        r_parity  <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: r_state <= ST_IDLE;
          ST_FILL: begin
            if (w_xfer) begin
              r_y       <= w_y_nxt;
              r_written <= w_written_nxt;
              if (auto_inc) begin
                r_cnt <= r_cnt + SEL_W'(1);
              end
              if (w_done) begin
                r_state      <= ST_HOLD;
                r_busy       <= 1'b0;
                r_word_valid <= 1'b1;
                r_parity     <= ^w_y_nxt;
              end
            end
          end
          ST_HOLD: r_state <= ST_HOLD;
          default: begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign Y          = r_y;
  assign written    = r_written;
  assign word_valid = r_word_valid;
  assign busy       = r_busy;
  assign in_ready   = r_busy;
`ifdef DEMUX_PARITY_EN
  assign parity     = r_parity;
`else
  logic w_unused_parity;
  assign w_unused_parity = r_parity;
`endif

endmodule

// File: tb/tb_demux_1to32_reg.sv
// Self-checking bench for demux_1to32_reg: directed tables, corner sequences and
// randomized traffic against a behavioural word-assembly model.
module tb_demux_1to32_reg;

  logic        clk;
  logic        rst;
  logic        start;
  logic        in_valid;
  logic        in_ready;
  logic        in_bit;
  logic [4:0]  sel;
  logic        auto_inc;
  logic [31:0] Y;
  logic [31:0] written;
  logic        word_valid;
  logic        busy;
`ifdef DEMUX_PARITY_EN
  logic        parity;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model: phase 0=idle, 1=filling, 2=holding.
  int          m_phase;
  logic [31:0] m_y;
  logic [31:0] m_mask;
  int          m_cnt;
  logic        m_wv;
  logic        m_par;

  demux_1to32_reg dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_bit     (in_bit),
    .sel        (sel),
    .auto_inc   (auto_inc),
    .Y          (Y),
    .written    (written),
`ifdef DEMUX_PARITY_EN
    .parity     (parity),
`endif
    .word_valid (word_valid),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    int idx;
    if (rst) begin
      m_phase = 0; m_y = '0; m_mask = '0; m_cnt = 0; m_wv = 1'b0; m_par = 1'b0;
    end else begin
      m_wv = 1'b0;
      if (start) begin
        m_phase = 1; m_y = '0; m_mask = '0; m_cnt = 0; m_par = 1'b0;
      end else if (m_phase == 1 && in_valid) begin
        idx = auto_inc ? m_cnt : int'(sel);
        m_y[idx]    = in_bit;
        m_mask[idx] = 1'b1;
        if (auto_inc) m_cnt = (m_cnt + 1) % 32;
        if (m_mask == 32'hFFFF_FFFF) begin
          m_phase = 2; m_wv = 1'b1; m_par = ^m_y;
        end
      end
    end
  endtask

  task automatic cmp_model();
    chk("Y", Y, m_y);
    chk("written", written, m_mask);
    chk("word_valid", 32'(word_valid), 32'(m_wv));
    chk("in_ready", 32'(in_ready), 32'(m_phase == 1));
    chk("busy", 32'(busy), 32'(m_phase == 1));
`ifdef DEMUX_PARITY_EN
    chk("parity", 32'(parity), 32'(m_par));
`endif
  endtask

  // One clock: drive at negedge, update model at posedge, compare just after it.
  task automatic step(input logic r, input logic s, input logic v, input logic b,
                      input logic [4:0] sl, input logic a);
    rst = r; start = s; in_valid = v; in_bit = b; sel = sl; auto_inc = a;
    @(posedge clk);
    model_step();
    #1;
    cmp_model();
    @(negedge clk);
  endtask

  task automatic load_word(input logic [31:0] w, output int wv_seen);
    wv_seen = 0;
    step(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1);
    for (int i = 0; i < 32; i++) begin
      step(1'b0, 1'b0, 1'b1, w[i], 5'd0, 1'b1);
      if (word_valid) wv_seen++;
    end
  endtask

  typedef struct {
    logic       start;
    logic       valid;
    logic       bit_in;
    logic [4:0] sel;
    logic       exp_wv;
    logic       exp_ready;
  } vec_t;

  vec_t vtab[35];

  initial begin
    int wv_cnt;
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_bit = 1'b0; sel = '0; auto_inc = 1'b0;
    m_phase = 0; m_y = '0; m_mask = '0; m_cnt = 0; m_wv = 1'b0; m_par = 1'b0;

    // Sel-addressed fill: 31 down to 1, rewrite 7 with 0, then 0 completes the word.
    vtab[0] = '{1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1};
    for (int i = 1; i <= 31; i++) vtab[i] = '{1'b0, 1'b1, 1'b1, 5'(32 - i), 1'b0, 1'b1};
    vtab[32] = '{1'b0, 1'b1, 1'b0, 5'd7, 1'b0, 1'b1};
    vtab[33] = '{1'b0, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0};
    vtab[34] = '{1'b0, 1'b1, 1'b1, 5'd3, 1'b0, 1'b0};

    @(negedge clk);
    // Reset held two cycles.
    step(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    chk("rst_Y", Y, 32'h0);
    chk("rst_ready", 32'(in_ready), 32'h0);
    // IDLE ignores in_valid.
    step(1'b0, 1'b0, 1'b1, 1'b1, 5'd4, 1'b0);
    chk("idle_ignore", Y, 32'h0);

    // Auto-increment fill, LSB first.
    load_word(32'hA5A5_3C3C, wv_cnt);
    chk("auto_Y", Y, 32'hA5A5_3C3C);
    chk("auto_wv_now", 32'(word_valid), 32'h1);
    step(1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b1);
    if (word_valid) wv_cnt++;
    step(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1);
    if (word_valid) wv_cnt++;
    chk("auto_wv_pulses", 32'(wv_cnt), 32'd1);
    chk("auto_hold_Y", Y, 32'hA5A5_3C3C);
    chk("auto_hold_ready", 32'(in_ready), 32'h0);

    // Table-driven sel-addressed sequence.
    for (int i = 0; i < 35; i++) begin
      step(1'b0, vtab[i].start, vtab[i].valid, vtab[i].bit_in, vtab[i].sel, 1'b0);
      chk($sformatf("tab%0d_wv", i), 32'(word_valid), 32'(vtab[i].exp_wv));
      chk($sformatf("tab%0d_ready", i), 32'(in_ready), 32'(vtab[i].exp_ready));
    end
    chk("sel_Y", Y, 32'hFFFF_FF7F);

    // Start coinciding with a transfer: restart wins, bit dropped, counter cleared.
    step(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1);
    for (int i = 0; i < 30; i++) step(1'b0, 1'b0, 1'b1, 1'b1, 5'd0, 1'b1);
    chk("pre_restart_mask", written, 32'h3FFF_FFFF);
    step(1'b0, 1'b1, 1'b1, 1'b1, 5'd0, 1'b1);
    chk("restart_Y", Y, 32'h0);
    chk("restart_mask", written, 32'h0);
    step(1'b0, 1'b0, 1'b1, 1'b1, 5'd9, 1'b1);
    chk("restart_cnt0", Y, 32'h0000_0001);

    // Reset in the middle of a fill.
    step(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b1, 1'b1, 5'd0, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b1, 5'd0, 1'b1);
    chk("midrst_Y", Y, 32'h0);
    chk("midrst_busy", 32'(busy), 32'h0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0);
    chk("midrst_restart", 32'(busy), 32'h1);

`ifdef DEMUX_PARITY_EN
    load_word(32'h0000_0007, wv_cnt);
    chk("par7_wv", 32'(word_valid), 32'h1);
    chk("par7", 32'(parity), 32'h1);
    load_word(32'h0000_0003, wv_cnt);
    chk("par3_wv", 32'(word_valid), 32'h1);
    chk("par3", 32'(parity), 32'h0);
`endif

    // Start in HOLD on the word_valid cycle.
    load_word(32'h1234_5678, wv_cnt);
    step(1'b0, 1'b1, 1'b1, 1'b1, 5'd0, 1'b1);
    chk("hold_start_wv", 32'(word_valid), 32'h0);
    chk("hold_start_busy", 32'(busy), 32'h1);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 299) == 0), ($urandom_range(0, 149) == 0),
           ($urandom_range(0, 3) != 0), 1'($urandom), 5'($urandom), 1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
